// File: rtl/apb_master_interface.sv
// ---------------------------------------------------------------------------
// apb_master_interface
//
// APB initiator that turns a simple valid/ready command port into APB SETUP
// and ACCESS phases. It waits on pready_i for a bounded number of ACCESS
// cycles and then reports a one-cycle response with read data. A transfer
// that never sees pready_i is reported with rsp_timeout_o set.
//
// Ports:
//   pclk_i        - clock, rising edge
//   preset_ni     - asynchronous active-low reset
//   cmd_valid_i   - command request
//   cmd_ready_o   - high while idle; command accepted when valid & ready
//   cmd_write_i   - 1 = write, 0 = read
//   cmd_addr_i    - target register address
//   cmd_wdata_i   - write data
//   rsp_valid_o   - one-cycle pulse when a transfer finishes
//   rsp_rdata_o   - read data (0 for writes and timeouts)
//   rsp_timeout_o - qualifies rsp_valid_o: transfer aborted on timeout
//   paddr_o, pwrite_o, psel_o, penable_o, pwdata_o - APB request signals
//   prdata_i, pready_i                             - APB completion signals
// ---------------------------------------------------------------------------
module apb_master_interface #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    // Ready is a pure decode of the state so it reads 1 while reset is held.
    assign cmd_ready_o = (state_q == IDLE);

    // Next-state and next-output computation. The address/data/direction
    // registers are only loaded on the accept edge, so they stay stable for
    // the whole transfer and keep their values afterwards. Response outputs
    // default to 0 so that rsp_valid_o is a single-cycle pulse.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    paddr_d   = cmd_addr_i;
                    pwrite_d  = cmd_write_i;
                    pwdata_d  = cmd_wdata_i;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Slave never answered: abort and flag the response.
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, which also
    // drops psel_o/penable_o immediately and suppresses any pending response.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign paddr_o       = paddr_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_interface.sv
// ---------------------------------------------------------------------------
// tb_apb_master_interface
//
// Directed bench for apb_master_interface. Each task drives one scenario and
// compares outputs against hand-computed values. Inputs change 1 time unit
// after the rising edge, and outputs are sampled at that same point, so every
// sample shows the state left by the preceding edge.
// ---------------------------------------------------------------------------
module tb_apb_master_interface;

    logic       pclk_i = 1'b0;
    logic       preset_ni = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_write_i = 1'b0;
    logic [7:0] cmd_addr_i = 8'h00;
    logic [7:0] cmd_wdata_i = 8'h00;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic       rsp_timeout_o;
    logic [7:0] paddr_o;
    logic       pwrite_o;
    logic       psel_o;
    logic       penable_o;
    logic [7:0] pwdata_o;
    logic [7:0] prdata_i = 8'h00;
    logic       pready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    apb_master_interface #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk_i       (pclk_i),
        .preset_ni    (preset_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_timeout_o(rsp_timeout_o),
        .paddr_o      (paddr_o),
        .pwrite_o     (pwrite_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwdata_o     (pwdata_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i)
    );

    always #5 pclk_i = ~pclk_i;

    // Step to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge pclk_i);
        #1;
    endtask

    // Reset values, including cmd_ready_o reading 1 while reset is held.
    task automatic test_reset();
        #2 preset_ni = 1'b0;
        #1;
        checks++;
        if ({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_timeout_o, cmd_ready_o} !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000001", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_timeout_o, cmd_ready_o});
        end
        checks++;
        if ({paddr_o, pwdata_o, rsp_rdata_o} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 000000", {paddr_o, pwdata_o, rsp_rdata_o});
        end
        repeat (2) @(posedge pclk_i);
        #3 preset_ni = 1'b1;
        step();
    endtask

    // Single write with immediate pready: SETUP, ACCESS, response.
    task automatic test_write();
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 8'h00; cmd_wdata_i = 8'h92;
        pready_i = 1'b1;
        step();
        cmd_valid_i = 1'b0; cmd_wdata_i = 8'h00;
        checks++;
        if ({psel_o, penable_o, pwrite_o, cmd_ready_o, rsp_valid_o} !== 5'b10100) begin
            errors++;
            $display("[TB] FAIL wr_setup got %b want 10100", {psel_o, penable_o, pwrite_o, cmd_ready_o, rsp_valid_o});
        end
        checks++;
        if ({paddr_o, pwdata_o} !== 16'h0092) begin
            errors++;
            $display("[TB] FAIL wr_setup_data got %h want 0092", {paddr_o, pwdata_o});
        end
        step();
        checks++;
        if ({psel_o, penable_o, paddr_o, pwdata_o} !== {2'b11, 16'h0092}) begin
            errors++;
            $display("[TB] FAIL wr_access got %b_%h want 11_0092", {psel_o, penable_o}, {paddr_o, pwdata_o});
        end
        step();
        checks++;
        if ({psel_o, penable_o, rsp_valid_o, rsp_timeout_o, cmd_ready_o, rsp_rdata_o} !== {5'b00101, 8'h00}) begin
            errors++;
            $display("[TB] FAIL wr_rsp got %b_%h want 00101_00", {psel_o, penable_o, rsp_valid_o, rsp_timeout_o, cmd_ready_o}, rsp_rdata_o);
        end
        step();
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_rsp_pulse got %b want 0", rsp_valid_o);
        end
    endtask

    // Single read; the returned prdata shows up on rsp_rdata_o.
    task automatic test_read();
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h01;
        pready_i = 1'b1; prdata_i = 8'hF1;
        step();
        cmd_valid_i = 1'b0;
        checks++;
        if ({psel_o, penable_o, pwrite_o, paddr_o} !== {3'b100, 8'h01}) begin
            errors++;
            $display("[TB] FAIL rd_setup got %b_%h want 100_01", {psel_o, penable_o, pwrite_o}, paddr_o);
        end
        step();
        checks++;
        if ({psel_o, penable_o, pwrite_o} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rd_access got %b want 110", {psel_o, penable_o, pwrite_o});
        end
        step();
        checks++;
        if ({rsp_valid_o, rsp_timeout_o, rsp_rdata_o, psel_o} !== {2'b10, 8'hF1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rd_rsp got %b_%h_%b want 10_f1_0", {rsp_valid_o, rsp_timeout_o}, rsp_rdata_o, psel_o);
        end
        step();
    endtask

    // Read with three wait states; prdata only matters on the pready edge.
    task automatic test_wait_states();
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h01;
        pready_i = 1'b0; prdata_i = 8'hEE;
        step();
        cmd_valid_i = 1'b0; cmd_addr_i = 8'h7F;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({psel_o, penable_o, pwrite_o, paddr_o, rsp_valid_o} !== {3'b110, 8'h01, 1'b0}) begin
                errors++;
                $display("[TB] FAIL wait_hold%0d got %b_%h_%b want 110_01_0", i, {psel_o, penable_o, pwrite_o}, paddr_o, rsp_valid_o);
            end
        end
        pready_i = 1'b1; prdata_i = 8'h14;
        step();
        checks++;
        if ({rsp_valid_o, rsp_timeout_o, rsp_rdata_o, penable_o} !== {2'b10, 8'h14, 1'b0}) begin
            errors++;
            $display("[TB] FAIL wait_rsp got %b_%h_%b want 10_14_0", {rsp_valid_o, rsp_timeout_o}, rsp_rdata_o, penable_o);
        end
        step();
    endtask

    // pready never arrives: 16 ACCESS cycles then a timeout response.
    task automatic test_timeout();
        int held;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h05;
        pready_i = 1'b0; prdata_i = 8'h5A;
        step();
        cmd_valid_i = 1'b0;
        step();
        held = (penable_o === 1'b1) ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (penable_o === 1'b1 && rsp_valid_o === 1'b0) held++;
        end
        checks++;
        if (held !== 16) begin
            errors++;
            $display("[TB] FAIL to_access_cycles got %0d want 16", held);
        end
        step();
        checks++;
        if ({psel_o, penable_o, rsp_valid_o, rsp_timeout_o, rsp_rdata_o, cmd_ready_o} !== {4'b0011, 8'h00, 1'b1}) begin
            errors++;
            $display("[TB] FAIL to_rsp got %b_%h_%b want 0011_00_1", {psel_o, penable_o, rsp_valid_o, rsp_timeout_o}, rsp_rdata_o, cmd_ready_o);
        end
        // Next command must go through normally.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 8'h03; cmd_wdata_i = 8'h33;
        pready_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        checks++;
        if ({rsp_valid_o, psel_o, paddr_o, pwdata_o} !== {2'b01, 16'h0333}) begin
            errors++;
            $display("[TB] FAIL to_next_accept got %b_%h want 01_0333", {rsp_valid_o, psel_o}, {paddr_o, pwdata_o});
        end
        repeat (2) step();
        checks++;
        if ({rsp_valid_o, rsp_timeout_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL to_next_rsp got %b want 10", {rsp_valid_o, rsp_timeout_o});
        end
        step();
    endtask

    // cmd_valid held high: second accept on the edge after completion.
    task automatic test_back_to_back();
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 8'h00; cmd_wdata_i = 8'hAA;
        pready_i = 1'b1; prdata_i = 8'h00;
        step();
        // Next command presented early; it must not disturb the current one.
        cmd_write_i = 1'b0; cmd_addr_i = 8'h01; cmd_wdata_i = 8'h00;
        step();
        checks++;
        if ({psel_o, penable_o, pwrite_o, cmd_ready_o, paddr_o, pwdata_o} !== {4'b1110, 16'h00AA}) begin
            errors++;
            $display("[TB] FAIL b2b_first_access got %b_%h want 1110_00aa", {psel_o, penable_o, pwrite_o, cmd_ready_o}, {paddr_o, pwdata_o});
        end
        prdata_i = 8'h3C;
        step();
        checks++;
        if ({psel_o, rsp_valid_o, cmd_ready_o, rsp_rdata_o} !== {3'b011, 8'h00}) begin
            errors++;
            $display("[TB] FAIL b2b_first_rsp got %b_%h want 011_00", {psel_o, rsp_valid_o, cmd_ready_o}, rsp_rdata_o);
        end
        step();
        cmd_valid_i = 1'b0;
        checks++;
        if ({psel_o, penable_o, pwrite_o, rsp_valid_o, paddr_o} !== {4'b1000, 8'h01}) begin
            errors++;
            $display("[TB] FAIL b2b_second_accept got %b_%h want 1000_01", {psel_o, penable_o, pwrite_o, rsp_valid_o}, paddr_o);
        end
        repeat (2) step();
        checks++;
        if ({rsp_valid_o, rsp_timeout_o, rsp_rdata_o} !== {2'b10, 8'h3C}) begin
            errors++;
            $display("[TB] FAIL b2b_second_rsp got %b_%h want 10_3c", {rsp_valid_o, rsp_timeout_o}, rsp_rdata_o);
        end
        step();
    endtask

    // Reset during ACCESS: APB strobes drop at once, no response follows.
    task automatic test_reset_mid();
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h02;
        pready_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        repeat (2) step();
        #2 preset_ni = 1'b0;
        #1;
        checks++;
        if ({psel_o, penable_o, rsp_valid_o, cmd_ready_o} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rstmid_async got %b want 0001", {psel_o, penable_o, rsp_valid_o, cmd_ready_o});
        end
        pready_i = 1'b1;
        repeat (2) @(posedge pclk_i);
        #3 preset_ni = 1'b1;
        step();
        checks++;
        if ({psel_o, penable_o, rsp_valid_o, cmd_ready_o} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rstmid_after got %b want 0001", {psel_o, penable_o, rsp_valid_o, cmd_ready_o});
        end
        step();
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_no_rsp got %b want 0", rsp_valid_o);
        end
    endtask

    initial begin
        $display("[TB] starting apb_master_interface bench");
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guards against a hung run.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
